ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port clear_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have the ports cpu_req, cpu_we (1 bit each), cpu_addr and cpu_wdata (8 bits each), all inputs: the sequencer's RAM request, its write select (1 = write), address and write data.
REQ-004 The block SHALL have the ports ld_req, ld_we, ld_addr and ld_wdata, all inputs, with the same widths and meaning, for the serial program loader.
REQ-005 The block SHALL have the outputs cpu_gnt, ld_gnt (1 bit each): high for exactly the SETUP cycle of the owning requester's access.
REQ-006 The block SHALL have the outputs cpu_done, ld_done (1 bit each): a one-cycle pulse in the DONE cycle of the owner's access.
REQ-007 The block SHALL have the output rdata, 8 bits: read data, valid while *_done is high, held until the next read completes.
REQ-008 The block SHALL have the outputs ram_addr and ram_wdata (8 bits each) and ram_re, ram_we (1 bit each): the single RAM port.
REQ-009 The block SHALL have the input ram_rdata, 8 bits: RAM read data, sampled at the end of the ACCESS cycle.
REQ-010 The block SHALL have the output cpu_stall, 1 bit: freezes the sequencer timer, driven to its jam input.

Function
REQ-011 The state machine SHALL have four states: IDLE, SETUP, ACCESS, DONE.
REQ-012 IDLE SHALL go to SETUP when any request is high; otherwise it SHALL stay in IDLE.
REQ-013 On the IDLE->SETUP transition, the block SHALL record the winner as owner and latch its we, addr and wdata.
REQ-014 SETUP SHALL always go to ACCESS, ACCESS SHALL always go to DONE, and DONE SHALL always go to IDLE.
REQ-015 The minimum access period SHALL be 4 cycles, and the latency from a request sampled in IDLE to its done pulse SHALL be 3 cycles.
REQ-016 In SETUP, ram_addr SHALL hold the latched address, ram_re and ram_we SHALL be 0, and the owner's gnt SHALL be 1.
REQ-017 In ACCESS, ram_we (for a write) or ram_re (for a read) SHALL be 1 for exactly that cycle; ram_addr and ram_wdata SHALL stay stable.
REQ-018 For a read, rdata SHALL load ram_rdata at the end of ACCESS; for a write, rdata SHALL be unchanged.
REQ-019 ram_re and ram_we SHALL never be high in the same cycle, and neither SHALL be high outside ACCESS.
REQ-020 A request dropped after grant SHALL not abort the access; the access SHALL complete and the done pulse SHALL still fire.
REQ-021 A requester SHALL drop req in the cycle after its done pulse; a req still high in IDLE SHALL be treated as a new request.
REQ-022 cpu_stall SHALL be combinational and equal cpu_req AND NOT (state==DONE AND owner==CPU).
REQ-023 When both requests rise in the same IDLE cycle, the policy in REQ-026/REQ-027 SHALL decide the winner; the loser SHALL be served at the next IDLE if it is still requesting.
REQ-024 Inputs SHALL be sampled only in IDLE; changes to inputs in other states SHALL have no effect on the access in progress.

Reset
REQ-025 While clear_n is 0 at a clock edge, the block SHALL go to IDLE; all outputs SHALL be 0, owner SHALL be LOADER, and last_served SHALL be LOADER. An access in progress SHALL be aborted with no ram_we and no done pulse.

Configuration
REQ-026 Without ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority: the CPU always wins a conflict.
REQ-027 With ARB_ROUND_ROBIN_EN defined, a conflict SHALL go to the requester not in last_served; last_served SHALL update at every IDLE->SETUP transition. A lone requester SHALL always win.

Structure
REQ-028 The shared package minibit_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS, DONE), the owner encoding (CPU=0, LOADER=1) and DATA_W=8.
REQ-029 The block SHALL use one sub-module, arb_pick: a combinational winner selector taking cpu_req, ld_req and last_served and producing the winner; it holds the ARB_ROUND_ROBIN_EN variants.

Verification
REQ-030 CPU write: cpu_req=1, we=1, addr=0x12, wdata=0xA5 -> cpu_gnt at +1, ram_we with addr 0x12 and wdata 0xA5 at +2, cpu_done at +3, cpu_stall low at +3.
REQ-031 Loader read: ram_rdata=0x3C at addr 0x40 -> ld_done at +3 with rdata=0x3C; rdata is still 0x3C 5 cycles later.
REQ-032 Simultaneous requests, both held, fixed priority -> CPU done at +3, loader done at +7; with ARB_ROUND_ROBIN_EN and a repeated CPU request, grants alternate CPU, LD, CPU.
REQ-033 cpu_req dropped in ACCESS -> write still performed and cpu_done still pulses.
REQ-034 clear_n=0 in ACCESS of a write -> no ram_we, no done pulse, state IDLE and all outputs 0 on the next cycle.
REQ-035 Assertion over all tests: ram_re AND ram_we is never 1, and at most one gnt is high in any cycle.

Source files
------------

// File: rtl/minibit_pkg.sv
// Shared types for the minibit RAM port arbiter:
// access FSM states, owner encoding and data width.
package minibit_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    CPU    = 1'b0,
    LOADER = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between sequencer and loader.
// ARB_ROUND_ROBIN_EN selects round robin; default is CPU priority.
import minibit_pkg::*;

module arb_pick (
  input  logic   cpu_req,
  input  logic   ld_req,
  input  owner_t last_served,
  output owner_t winner
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = LOADER;
    if (cpu_req && ld_req) begin
      // a conflict goes to whoever was not served last
      if (last_served == CPU)
        winner = LOADER;
      else
        winner = CPU;
    end else if (cpu_req) begin
      winner = CPU;
    end
  end
`else
  logic unused_ls;
  assign unused_ls = last_served;

  always_comb begin
    winner = LOADER;
    if (cpu_req)
      winner = CPU;
    else if (ld_req)
      winner = LOADER;
  end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between sequencer and program loader.
// Fixed CPU priority unless ARB_ROUND_ROBIN_EN is defined.
import minibit_pkg::*;

module ram_port_arbiter (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [DATA_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              cpu_gnt,
  output logic              ld_gnt,
  output logic              cpu_done,
  output logic              ld_done,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_stall
);

  arb_state_t        state, state_nx;
  owner_t            owner, last_served, winner;
  logic              lat_we;
  logic [DATA_W-1:0] lat_addr, lat_wdata;
  logic              start;

  arb_pick u_pick (
    .cpu_req     (cpu_req),
    .ld_req      (ld_req),
    .last_served (last_served),
    .winner      (winner)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (cpu_req || ld_req) state_nx = SETUP;
      SETUP:  state_nx = ACCESS;
      ACCESS: state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign start = (state == IDLE) && (cpu_req || ld_req);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state       <= IDLE;
      owner       <= LOADER;
      last_served <= LOADER;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rdata       <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        owner       <= winner;
        last_served <= winner;
        if (winner == CPU) begin
          lat_we    <= cpu_we;
          lat_addr  <= cpu_addr;
          lat_wdata <= cpu_wdata;
        end else begin
          lat_we    <= ld_we;
          lat_addr  <= ld_addr;
          lat_wdata <= ld_wdata;
        end
      end
      if (state == ACCESS && !lat_we)
        rdata <= ram_rdata;
    end
  end

  assign cpu_gnt   = (state == SETUP) && (owner == CPU);
  assign ld_gnt    = (state == SETUP) && (owner == LOADER);
  assign cpu_done  = (state == DONE) && (owner == CPU);
  assign ld_done   = (state == DONE) && (owner == LOADER);
  assign ram_re    = (state == ACCESS) && !lat_we;
  assign ram_we    = (state == ACCESS) && lat_we;
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;
  // the sequencer resumes in the cycle its own access completes
  assign cpu_stall = cpu_req && !cpu_done;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter; expected values are
// hand-derived and checked with immediate assertions.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       cpu_req, cpu_we, ld_req, ld_we;
  logic [7:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
  logic       cpu_gnt, ld_gnt, cpu_done, ld_done;
  logic [7:0] rdata, ram_addr, ram_wdata, ram_rdata;
  logic       ram_re, ram_we, cpu_stall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .cpu_gnt   (cpu_gnt),
    .ld_gnt    (ld_gnt),
    .cpu_done  (cpu_done),
    .ld_done   (ld_done),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .cpu_stall (cpu_stall)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cgnt"}, {7'd0, cpu_gnt}, 8'd0);
    chk({tag, "_lgnt"}, {7'd0, ld_gnt}, 8'd0);
    chk({tag, "_cdone"}, {7'd0, cpu_done}, 8'd0);
    chk({tag, "_ldone"}, {7'd0, ld_done}, 8'd0);
    chk({tag, "_re"}, {7'd0, ram_re}, 8'd0);
    chk({tag, "_we"}, {7'd0, ram_we}, 8'd0);
  endtask

  always @(negedge clk) begin
    if (clear_n === 1'b1) begin
      tests++;
      assert (!(ram_re && ram_we) && !(cpu_gnt && ld_gnt))
      else begin
        fails++;
        $error("FAIL excl re=%b we=%b cg=%b lg=%b required no overlap",
               ram_re, ram_we, cpu_gnt, ld_gnt);
      end
    end
  end

  initial begin
    clear_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    ram_rdata = 8'h00;
    step(2);
    chk_quiet("rst");
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_addr", ram_addr, 8'h00);
    chk("rst_wdata", ram_wdata, 8'h00);
    chk("rst_stall", {7'd0, cpu_stall}, 8'd0);
    clear_n = 1'b1;
    step();

    // CPU write
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h12; cpu_wdata = 8'hA5;
    step();
    chk("w_gnt", {7'd0, cpu_gnt}, 8'd1);
    chk("w_lgnt", {7'd0, ld_gnt}, 8'd0);
    chk("w_setup_we", {7'd0, ram_we}, 8'd0);
    chk("w_setup_addr", ram_addr, 8'h12);
    chk("w_stall1", {7'd0, cpu_stall}, 8'd1);
    cpu_addr = 8'h77; cpu_wdata = 8'h00; cpu_we = 0;
    step();
    chk("w_we", {7'd0, ram_we}, 8'd1);
    chk("w_re", {7'd0, ram_re}, 8'd0);
    chk("w_addr", ram_addr, 8'h12);
    chk("w_wdata", ram_wdata, 8'hA5);
    step();
    chk("w_done", {7'd0, cpu_done}, 8'd1);
    chk("w_stall3", {7'd0, cpu_stall}, 8'd0);
    chk("w_we3", {7'd0, ram_we}, 8'd0);
    cpu_req = 0;
    step();
    chk_quiet("w_idle");

    // Loader read
    ld_req = 1; ld_we = 0; ld_addr = 8'h40; ram_rdata = 8'h3C;
    step();
    chk("r_gnt", {7'd0, ld_gnt}, 8'd1);
    step();
    chk("r_re", {7'd0, ram_re}, 8'd1);
    chk("r_addr", ram_addr, 8'h40);
    step();
    chk("r_done", {7'd0, ld_done}, 8'd1);
    chk("r_rdata", rdata, 8'h3C);
    ld_req = 0; ram_rdata = 8'h99;
    step(5);
    chk("r_hold", rdata, 8'h3C);

    // simultaneous, last served = loader so CPU wins in both modes
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h01; cpu_wdata = 8'h11;
    ld_req = 1; ld_we = 1; ld_addr = 8'h02; ld_wdata = 8'h22;
    step();
    chk("s_cgnt", {7'd0, cpu_gnt}, 8'd1);
    chk("s_lgnt", {7'd0, ld_gnt}, 8'd0);
    step(2);
    chk("s_cdone", {7'd0, cpu_done}, 8'd1);
    cpu_req = 0;
    step(2);
    chk("s_lgnt5", {7'd0, ld_gnt}, 8'd1);
    step();
    chk("s_laddr", ram_addr, 8'h02);
    chk("s_lwdata", ram_wdata, 8'h22);
    chk("s_lwe", {7'd0, ram_we}, 8'd1);
    step();
    chk("s_ldone7", {7'd0, ld_done}, 8'd1);
    chk("s_rdata_kept", rdata, 8'h3C);
    ld_req = 0;
    step();

    // both held; CPU re-requests continuously
    cpu_req = 1; ld_req = 1;
    step();
    chk("a_g1", {7'd0, cpu_gnt}, 8'd1);
    step(4);
`ifdef ARB_ROUND_ROBIN_EN
    chk("a_g2_ld", {7'd0, ld_gnt}, 8'd1);
`else
    chk("a_g2_cpu", {7'd0, cpu_gnt}, 8'd1);
`endif
    step(4);
    chk("a_g3", {7'd0, cpu_gnt}, 8'd1);
    cpu_req = 0; ld_req = 0;
    step(4);
    chk_quiet("a_idle");

    // request dropped after grant still completes
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h55; cpu_wdata = 8'h66;
    step();
    chk("d_gnt", {7'd0, cpu_gnt}, 8'd1);
    cpu_req = 0;
    step();
    chk("d_we", {7'd0, ram_we}, 8'd1);
    chk("d_addr", ram_addr, 8'h55);
    chk("d_wdata", ram_wdata, 8'h66);
    step();
    chk("d_done", {7'd0, cpu_done}, 8'd1);
    step();

    // reset during ACCESS of a write
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h33; cpu_wdata = 8'h44;
    step(2);
    chk("x_we_access", {7'd0, ram_we}, 8'd1);
    clear_n = 0; cpu_req = 0;
    step();
    chk_quiet("x_rst");
    chk("x_rdata", rdata, 8'h00);
    chk("x_addr", ram_addr, 8'h00);
    chk("x_wdata", ram_wdata, 8'h00);
    chk("x_stall", {7'd0, cpu_stall}, 8'd0);
    clear_n = 1;
    step();
    chk_quiet("x_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
